// File: rtl/servo_dec_pkg.sv
// Shared FSM state encoding, default timing constants and position helpers
// for the servo PWM decoder.
package servo_dec_pkg;

  typedef enum logic [1:0] {
    ST_ARM  = 2'd0,
    ST_IDLE = 2'd1,
    ST_OFFS = 2'd2,
    ST_MEAS = 2'd3
  } dec_state_t;

  localparam int DEF_OFFSET  = 6000;
  localparam int DEF_STEP    = 94;
  localparam int DEF_TIMEOUT = 300000;

  // Consecutive low samples required before arming; longer than the deepest
  // synchronizer/filter pipeline so flops cleared by reset cannot fake a low.
  localparam int ARM_LOW_CYCLES = 8;

  localparam logic [7:0] POS_MAX = 8'hFF;

  function automatic logic [7:0] pos_sat_inc(input logic [7:0] p);
    return (p == POS_MAX) ? POS_MAX : p + 8'd1;
  endfunction

endpackage

// File: rtl/pwm_edge_sync.sv
// Two-flop synchronizer, optional 3-sample glitch filter, registered edge detect.
// Define SERVO_DEC_GLITCH_FILTER_EN to include the glitch filter (+2 cycles latency).
module pwm_edge_sync (
  input  logic clk,
  input  logic rstn,
  input  logic servo,
  output logic level,
  output logic rise,
  output logic fall
);

  logic sync_p0, sync_p1, prev_p2;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= servo;
      sync_p1 <= sync_p0;
    end
  end

`ifdef SERVO_DEC_GLITCH_FILTER_EN
  logic hist_p0, hist_p1, filt_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      hist_p0 <= 1'b0;
      hist_p1 <= 1'b0;
      filt_q  <= 1'b0;
    end else begin
      hist_p0 <= sync_p1;
      hist_p1 <= hist_p0;
      filt_q  <= level;
    end
  end

  // Follow the input only once three consecutive samples agree.
  assign level = (sync_p1 == hist_p0 && hist_p0 == hist_p1) ? sync_p1 : filt_q;
`else
  assign level = sync_p1;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) prev_p2 <= 1'b0;
    else       prev_p2 <= level;
  end

  assign rise = level & ~prev_p2;
  assign fall = ~level & prev_p2;

endmodule

// File: rtl/servo_pwm_decoder.sv
// Servo PWM pulse-width decoder: measures each high pulse by counting and reports
// an 8-bit position with range flags, plus signal-loss detection.
// SERVO_DEC_GLITCH_FILTER_EN (see pwm_edge_sync) adds an input glitch filter.
module servo_pwm_decoder
  import servo_dec_pkg::*;
#(
  parameter int OFFSET  = DEF_OFFSET,
  parameter int STEP    = DEF_STEP,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       servo,
  output logic [7:0] pos,
  output logic       valid,
  output logic       under,
  output logic       over,
  output logic       lost
);

  localparam int OFF_W = $clog2(OFFSET + 1);
  localparam int PRE_W = $clog2(STEP + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int ARM_W = $clog2(ARM_LOW_CYCLES);

  // The rise cycle itself is the first high tick, so OFFS ends one count early.
  localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(OFFSET - 2);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT);
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_LOW_CYCLES - 1);

  logic level, rise, fall;

  pwm_edge_sync u_sync (
    .clk   (clk),
    .rstn  (rstn),
    .servo (servo),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  dec_state_t       state_q, state_d;
  logic [OFF_W-1:0] off_q, off_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             ovr_q, ovr_d;
  logic [ARM_W-1:0] arm_q, arm_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [7:0]       pos_d;
  logic             under_d, over_d, valid_d, lost_d;
  logic             tmo_hit;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_ARM;
      off_q   <= '0;
      pre_q   <= '0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
      arm_q   <= '0;
      tmo_q   <= '0;
      pos     <= '0;
      under   <= 1'b0;
      over    <= 1'b0;
      valid   <= 1'b0;
      lost    <= 1'b1;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
      arm_q   <= arm_d;
      tmo_q   <= tmo_d;
      pos     <= pos_d;
      under   <= under_d;
      over    <= over_d;
      valid   <= valid_d;
      lost    <= lost_d;
    end
  end

  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    ovr_d   = ovr_q;
    arm_d   = arm_q;
    pos_d   = pos;
    under_d = under;
    over_d  = over;
    valid_d = 1'b0;
    lost_d  = lost;

    // A rise in the terminal cycle cancels the timeout.
    tmo_hit = (tmo_q == TMO_LAST) && !rise;
    if (rise)                tmo_d = '0;
    else if (tmo_q == TMO_MAX) tmo_d = tmo_q;
    else                     tmo_d = tmo_q + 1'b1;

    case (state_q)
      ST_ARM: begin
        if (level) begin
          arm_d = '0;
        end else if (arm_q == ARM_LAST) begin
          arm_d   = '0;
          state_d = ST_IDLE;
        end else begin
          arm_d = arm_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (rise) begin
          off_d   = '0;
          pre_d   = '0;
          cnt_d   = '0;
          ovr_d   = 1'b0;
          state_d = ST_OFFS;
        end
      end
      ST_OFFS: begin
        if (fall) begin
          pos_d   = '0;
          under_d = 1'b1;
          over_d  = 1'b0;
          valid_d = 1'b1;
          state_d = ST_IDLE;
        end else if (off_q == OFF_LAST) begin
          state_d = ST_MEAS;
        end else begin
          off_d = off_q + 1'b1;
        end
      end
      ST_MEAS: begin
        if (fall) begin
          pos_d   = cnt_q;
          under_d = 1'b0;
          over_d  = ovr_q;
          valid_d = 1'b1;
          state_d = ST_IDLE;
        end else if (!ovr_q) begin
          if (pre_q == PRE_LAST) begin
            pre_d = '0;
            // The 256th position unit marks overflow and freezes counting.
            if (cnt_q == POS_MAX) ovr_d = 1'b1;
            else                  cnt_d = pos_sat_inc(cnt_q);
          end else begin
            pre_d = pre_q + 1'b1;
          end
        end
      end
      default: state_d = ST_ARM;
    endcase

    if (valid_d) lost_d = 1'b0;

    if (tmo_hit) begin
      state_d = ST_ARM;
      arm_d   = '0;
      valid_d = 1'b0;
      pos_d   = pos;
      under_d = under;
      over_d  = over;
      lost_d  = 1'b1;
    end
  end

endmodule
